// File: rtl/quant_write_combiner.sv
// Combines masked 256-bit group writes into full SRAMC word writes and queues them,
// with reads ordered behind them, to a stallable SRAM port. Optional idle eviction: WCB_TIMEOUT_EN.
module quant_write_combiner #(
    parameter int SRAMC_W     = 1024,
    parameter int ADRC_W      = 12,
    parameter int SRAMC_N     = 32,
    parameter int FIFO_DEPTH  = 4
`ifdef WCB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [SRAMC_W-1:0]   i_sramc_wdata_q,
    input  logic [ADRC_W-1:0]    i_sramc_addr_q,
    input  logic                 i_sramc_wren_q,
    input  logic [0:SRAMC_N-1]   i_sramc_wmask_q,
    input  logic                 i_sramc_rden_q,
    input  logic                 i_flush,
    input  logic                 i_sramc_stall,
    output logic [SRAMC_W-1:0]   o_sramc_wdata_q,
    output logic [ADRC_W-1:0]    o_sramc_addr_q,
    output logic                 o_sramc_wren_q,
    output logic [0:SRAMC_N-1]   o_sramc_wmask_q,
    output logic                 o_sramc_rden_q,
    output logic                 o_idle,
    output logic                 o_ovf,
    output logic                 o_err
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LANE_W = SRAMC_W / SRAMC_N;
    // FIFO entry layout: {is_write, addr, mask, data}
    localparam int ENT_W  = 1 + ADRC_W + SRAMC_N + SRAMC_W;

    logic                 r_buf_v;
    logic [ADRC_W-1:0]    r_buf_addr;
    logic [SRAMC_W-1:0]   r_buf_data;
    logic [0:SRAMC_N-1]   r_buf_mask;

    logic [ENT_W-1:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic [SRAMC_W-1:0]   r_out_data;
    logic [ADRC_W-1:0]    r_out_addr;
    logic                 r_out_wren;
    logic [0:SRAMC_N-1]   r_out_mask;
    logic                 r_out_rden;
    logic                 r_ovf;
    logic                 r_err;

    logic                 w_wr;
    logic                 w_rd;
    logic                 w_timeout;
    logic [SRAMC_W-1:0]   w_merged;
    logic                 w_nb_v;
    logic [ADRC_W-1:0]    w_nb_addr;
    logic [SRAMC_W-1:0]   w_nb_data;
    logic [0:SRAMC_N-1]   w_nb_mask;
    logic [1:0]           w_npush;
    logic [ENT_W-1:0]     w_e0;
    logic [ENT_W-1:0]     w_e1;
    logic                 w_pop;
    logic [CNT_W:0]       w_free;
    logic                 w_accept;
    logic                 w_drop;
    logic [ENT_W-1:0]     w_head;

    assign w_wr = i_sramc_wren_q & ~i_sramc_rden_q & (|i_sramc_wmask_q);
    assign w_rd = i_sramc_rden_q & ~i_sramc_wren_q;

`ifdef WCB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;

    assign w_timeout = r_buf_v & ~i_sramc_wren_q & (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_to_cnt <= '0;
        end else if (w_wr || w_timeout || !r_buf_v) begin
            r_to_cnt <= '0;
        end else if (!i_sramc_wren_q) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_merged = r_buf_data;
        for (int i = 0; i < SRAMC_N; i++) begin
            if (i_sramc_wmask_q[i]) begin
                w_merged[LANE_W*i +: LANE_W] = i_sramc_wdata_q[LANE_W*i +: LANE_W];
            end
        end
    end

    // Evictions are collected in input order into at most two push slots.
    always_comb begin
        w_nb_v    = r_buf_v;
        w_nb_addr = r_buf_addr;
        w_nb_data = r_buf_data;
        w_nb_mask = r_buf_mask;
        w_npush   = 2'd0;
        w_e0      = '0;
        w_e1      = '0;

        if (w_wr) begin
            if (r_buf_v && (i_sramc_addr_q == r_buf_addr)) begin
                w_nb_data = w_merged;
                w_nb_mask = r_buf_mask | i_sramc_wmask_q;
            end else begin
                if (r_buf_v) begin
                    w_e0    = {1'b1, r_buf_addr, r_buf_mask, r_buf_data};
                    w_npush = 2'd1;
                end
                w_nb_v    = 1'b1;
                w_nb_addr = i_sramc_addr_q;
                w_nb_data = i_sramc_wdata_q;
                w_nb_mask = i_sramc_wmask_q;
            end
        end

        if (w_nb_v && ((&w_nb_mask) || i_flush || w_timeout)) begin
            if (w_npush == 2'd0) begin
                w_e0 = {1'b1, w_nb_addr, w_nb_mask, w_nb_data};
            end else begin
                w_e1 = {1'b1, w_nb_addr, w_nb_mask, w_nb_data};
            end
            w_npush = w_npush + 2'd1;
            w_nb_v  = 1'b0;
        end

        if (w_rd) begin
            if (w_nb_v) begin
                w_e0    = {1'b1, w_nb_addr, w_nb_mask, w_nb_data};
                w_npush = 2'd1;
                w_nb_v  = 1'b0;
            end
            if (w_npush == 2'd0) begin
                w_e0 = {1'b0, i_sramc_addr_q, {SRAMC_N{1'b0}}, {SRAMC_W{1'b0}}};
            end else begin
                w_e1 = {1'b0, i_sramc_addr_q, {SRAMC_N{1'b0}}, {SRAMC_W{1'b0}}};
            end
            w_npush = w_npush + 2'd1;
        end
    end

    // A pop in the same cycle frees its slot for this cycle's pushes.
    assign w_pop    = ~i_sramc_stall & (r_count != '0);
    assign w_free   = (CNT_W+1)'(FIFO_DEPTH) - {1'b0, r_count} + (CNT_W+1)'(w_pop);
    assign w_accept = ((CNT_W+1)'(w_npush) <= w_free);
    assign w_drop   = (w_npush != 2'd0) & ~w_accept;
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_accept && (w_npush != 2'd0)) begin
            r_mem[r_wr_ptr] <= w_e0;
            if (w_npush == 2'd2) begin
                r_mem[r_wr_ptr + PTR_W'(1)] <= w_e1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_buf_v    <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
            r_buf_mask <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_buf_v    <= w_nb_v;
            r_buf_addr <= w_nb_addr;
            r_buf_data <= w_nb_data;
            r_buf_mask <= w_nb_mask;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(w_npush);
                r_count  <= r_count + CNT_W'(w_npush) - CNT_W'(w_pop);
            end else begin
                r_count  <= r_count - CNT_W'(w_pop);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (i_sramc_wren_q && i_sramc_rden_q) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_out_data <= '0;
            r_out_addr <= '0;
            r_out_wren <= 1'b0;
            r_out_mask <= '0;
            r_out_rden <= 1'b0;
        end else if (!i_sramc_stall) begin
            if (r_count != '0) begin
                r_out_wren <= w_head[ENT_W-1];
                r_out_rden <= ~w_head[ENT_W-1];
                r_out_addr <= w_head[ENT_W-2 -: ADRC_W];
                r_out_mask <= w_head[SRAMC_N+SRAMC_W-1 -: SRAMC_N];
                r_out_data <= w_head[SRAMC_W-1:0];
            end else begin
                r_out_wren <= 1'b0;
                r_out_rden <= 1'b0;
            end
        end
    end

    assign o_sramc_wdata_q = r_out_data;
    assign o_sramc_addr_q  = r_out_addr;
    assign o_sramc_wren_q  = r_out_wren;
    assign o_sramc_wmask_q = r_out_mask;
    assign o_sramc_rden_q  = r_out_rden;
    assign o_ovf           = r_ovf;
    assign o_err           = r_err;
    assign o_idle          = ~r_buf_v & (r_count == '0) & ~r_out_wren & ~r_out_rden;

endmodule
